// File: rtl/bus_arb_pkg.sv
// ----------------------------------------------------------------------------
// bus_arb_pkg
//   Shared types and constants for the two-master bus arbiter.
//   - arb_state_e : arbiter FSM encoding (also exported for debug/observation)
//   - bus_req_t   : one latched master request (byte enables, address, data)
//   - is_write()  : a request is a write when any byte enable is set
// ----------------------------------------------------------------------------
package bus_arb_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_BE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [BUS_BE-1:0] we;
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
    } bus_req_t;

    // All-zero byte enables encode a read.
    function automatic logic is_write(input logic [BUS_BE-1:0] we);
        return |we;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_if
//   Bundles the master request/acknowledge handshakes and the downstream bus
//   that bus_arbiter sits between.
//
//   Handshake (both masters): a master raises mN_req with mN_we/mN_addr/
//   mN_wdata stable and keeps them until it sees mN_ack high for one cycle.
//   req acts as "valid", ack as a one-cycle "done"; there is no separate
//   ready. m_rdata is only meaningful in the cycle an ack is high. A master
//   may withdraw req early once it has been granted; the access still
//   completes and the ack still pulses.
//
//   Signals:
//     m0_*/m1_*   master request fields and acknowledge
//     m_rdata     read data returned to whichever master is acked
//     bus_*       strobes/address/data toward bus_controller, bus_rdata back
//     busy/owner  arbiter status; state is the raw FSM state for observation
//
//   Modports:
//     slave   : the arbiter's view
//     master  : the environment's view (masters + bus model)
//     monitor : passive observer
// ----------------------------------------------------------------------------
interface bus_arbiter_if
    import bus_arb_pkg::*;
();

    logic              m0_req;
    logic [BUS_BE-1:0] m0_we;
    logic [BUS_AW-1:0] m0_addr;
    logic [BUS_DW-1:0] m0_wdata;
    logic              m0_ack;

    logic              m1_req;
    logic [BUS_BE-1:0] m1_we;
    logic [BUS_AW-1:0] m1_addr;
    logic [BUS_DW-1:0] m1_wdata;
    logic              m1_ack;

    logic [BUS_DW-1:0] m_rdata;

    logic              bus_re;
    logic [BUS_BE-1:0] bus_we;
    logic [BUS_AW-1:0] bus_addr;
    logic [BUS_DW-1:0] bus_wdata;
    logic [BUS_DW-1:0] bus_rdata;

    logic              busy;
    logic              owner;
    arb_state_e        state;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bus_rdata,
        output m0_ack, m1_ack, m_rdata,
        output bus_re, bus_we, bus_addr, bus_wdata,
        output busy, owner, state
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bus_rdata,
        input  m0_ack, m1_ack, m_rdata,
        input  bus_re, bus_we, bus_addr, bus_wdata,
        input  busy, owner, state
    );

    modport monitor (
        input m0_req, m0_we, m0_addr, m0_wdata,
        input m1_req, m1_we, m1_addr, m1_wdata,
        input bus_rdata,
        input m0_ack, m1_ack, m_rdata,
        input bus_re, bus_we, bus_addr, bus_wdata,
        input busy, owner, state
    );

endinterface

// File: rtl/bus_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Combinational two-requester round-robin pick.
//
//   Ports:
//     req[1:0]     request from master 1 / master 0
//     last         index of the master that was served most recently
//     grant_valid  at least one request is present
//     grant_idx    winning master (0 when nobody requests)
//
//   A lone requester always wins; on a tie the master that was not served
//   last wins, which makes grants strictly alternate under contention.
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Shares one data bus between the CPU load/store port (master 0) and a
//   DMA/loader engine (master 1). One transaction is in flight at a time:
//   IDLE picks a winner and latches its request, ISSUE drives the bus for one
//   cycle, WAIT covers the remaining read latency, ACK pulses the winner's ack
//   with the captured read data.
//
//   Parameters:
//     RD_LAT   bus cycles after the issue cycle before bus_rdata is valid
//              (legal range 0..3; the latency counter is two bits wide)
//
//   Ports:
//     clk      system clock, rising edge
//     rst_n    synchronous active-low reset
//     bif      bus_arbiter_if.slave: master handshakes, bus side, status
//
//   Every output comes straight from a register; no request input reaches a
//   bus strobe combinationally.
// ----------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_arbiter_if.slave bif
);

    // Value loaded into the latency counter on a read issue. With RD_LAT = 0
    // the read completes in ISSUE and the counter is never used.
    localparam logic [1:0] LAT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    arb_state_e        state_q;
    logic              last_q;     // master served most recently
    logic              owner_q;    // master currently or last granted
    bus_req_t          req_q;      // latched winning request
    logic [1:0]        cnt_q;      // remaining read-latency cycles in WAIT
    logic [BUS_DW-1:0] rdata_q;    // captured read data
    logic              bus_re_q;
    logic [BUS_BE-1:0] bus_we_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              busy_q;

    // ------------------------------------------------------------------
    // Arbitration and request selection
    // ------------------------------------------------------------------
    logic     grant_valid;
    logic     grant_idx;
    bus_req_t req_d;               // fields of the would-be winner

    rr_arb2 u_rr_arb2 (
        .req         ({bif.m1_req, bif.m0_req}),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        req_d.we    = bif.m0_we;
        req_d.addr  = bif.m0_addr;
        req_d.wdata = bif.m0_wdata;
        if (grant_idx) begin
            req_d.we    = bif.m1_we;
            req_d.addr  = bif.m1_addr;
            req_d.wdata = bif.m1_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Single FSM. Strobes and acks are set on the edge that enters the
    // state in which they must be visible, so each output is a plain
    // register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;          // master 0 wins the first tie
            owner_q  <= 1'b0;
            req_q    <= '0;
            cnt_q    <= 2'd0;
            rdata_q  <= '0;
            bus_re_q <= 1'b0;
            bus_we_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q  <= grant_idx;
                        req_q    <= req_d;
                        // Strobes go up on entry to ISSUE.
                        bus_we_q <= req_d.we;
                        bus_re_q <= ~is_write(req_d.we);
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (is_write(req_q.we)) begin
                        bus_we_q <= '0;
                        ack0_q   <= ~owner_q;
                        ack1_q   <= owner_q;
                        state_q  <= ACK;
                    end else if (RD_LAT == 0) begin
                        // Zero-latency bus: data is valid in the issue cycle.
                        rdata_q  <= bif.bus_rdata;
                        bus_re_q <= 1'b0;
                        ack0_q   <= ~owner_q;
                        ack1_q   <= owner_q;
                        state_q  <= ACK;
                    end else begin
                        // bus_re stays high through WAIT.
                        cnt_q    <= LAT_LOAD;
                        state_q  <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        rdata_q  <= bif.bus_rdata;
                        bus_re_q <= 1'b0;
                        ack0_q   <= ~owner_q;
                        ack1_q   <= owner_q;
                        state_q  <= ACK;
                    end else begin
                        cnt_q    <= cnt_q - 2'd1;
                    end
                end

                ACK: begin
                    // The acked master's req is still high here; it is not
                    // looked at again until IDLE.
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    last_q   <= owner_q;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end

                default: begin
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bif.m0_ack    = ack0_q;
    assign bif.m1_ack    = ack1_q;
    assign bif.m_rdata   = rdata_q;
    assign bif.bus_re    = bus_re_q;
    assign bif.bus_we    = bus_we_q;
    // Address and write data hold the latched request outside ISSUE/WAIT.
    assign bif.bus_addr  = req_q.addr;
    assign bif.bus_wdata = req_q.wdata;
    assign bif.busy      = busy_q;
    assign bif.owner     = owner_q;
    assign bif.state     = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three lanes built with RD_LAT = 0, 1 and 3 share one
// clock/reset and receive the same directed phases, then random traffic.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int NL = 3;

  function automatic int lat_of(input int l);
    return (l == 0) ? 0 : ((l == 1) ? 1 : 3);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus (per lane, per master) ----------------
  logic        rq[NL][2];
  logic [3:0]  we_a[NL][2];
  logic [31:0] ad_a[NL][2];
  logic [31:0] wd_a[NL][2];
  logic [31:0] bus_rdata[NL];
  logic [31:0] resp[NL];
  int          re_run[NL];
  bit          waiting[NL][2];
  int          mode;      // 0 directed, 1 contention, 2 random
  bit          chk_en;

  // ---------------- observed ----------------
  logic        o_ack0[NL], o_ack1[NL], o_re[NL], o_busy[NL], o_owner[NL];
  logic [3:0]  o_we[NL];
  logic [31:0] o_addr[NL], o_wdata[NL], o_rdata[NL];
  arb_state_e  o_state[NL];

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    bus_arbiter_if bif ();
    bus_arbiter #(.RD_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bif(bif.slave));
    assign bif.m0_req = rq[g][0];
    assign bif.m0_we = we_a[g][0];
    assign bif.m0_addr = ad_a[g][0];
    assign bif.m0_wdata = wd_a[g][0];
    assign bif.m1_req = rq[g][1];
    assign bif.m1_we = we_a[g][1];
    assign bif.m1_addr = ad_a[g][1];
    assign bif.m1_wdata = wd_a[g][1];
    assign bif.bus_rdata = bus_rdata[g];
    assign o_ack0[g] = bif.m0_ack;
    assign o_ack1[g] = bif.m1_ack;
    assign o_re[g] = bif.bus_re;
    assign o_we[g] = bif.bus_we;
    assign o_addr[g] = bif.bus_addr;
    assign o_wdata[g] = bif.bus_wdata;
    assign o_rdata[g] = bif.m_rdata;
    assign o_busy[g] = bif.busy;
    assign o_owner[g] = bif.owner;
    assign o_state[g] = bif.state;
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int l, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lane%0d (RD_LAT=%0d) got %h expected %h", nm, l, lat_of(l), got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transaction is described by its offset t from the grant edge:
  // t = 0 is the issue cycle, strobes are up for dur cycles, the ack is at
  // t = dur, and the following cycle is idle.
  bit          m_act[NL];
  int          m_t[NL];
  int          m_dur[NL];
  bit          m_rd[NL];
  bit          m_own[NL];
  bit          m_last[NL];
  logic [3:0]  m_we[NL];
  logic [31:0] m_addr[NL], m_wdata[NL], m_rdat[NL];
  bit          m_win;

  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (!rst_n) begin
        m_act[l] = 1'b0; m_t[l] = 0; m_dur[l] = 0; m_rd[l] = 1'b0;
        m_own[l] = 1'b0; m_last[l] = 1'b1; m_we[l] = '0;
        m_addr[l] = '0; m_wdata[l] = '0; m_rdat[l] = '0;
      end else if (m_act[l]) begin
        if (m_rd[l] && m_t[l] == m_dur[l] - 1) m_rdat[l] = bus_rdata[l];
        if (m_t[l] == m_dur[l]) begin
          m_act[l] = 1'b0;
          m_last[l] = m_own[l];
        end else begin
          m_t[l]++;
        end
      end else if (rq[l][0] || rq[l][1]) begin
        m_win = (rq[l][0] && rq[l][1]) ? !m_last[l] : rq[l][1];
        m_own[l] = m_win;
        m_we[l] = we_a[l][m_win];
        m_addr[l] = ad_a[l][m_win];
        m_wdata[l] = wd_a[l][m_win];
        m_rd[l] = (we_a[l][m_win] == 4'd0);
        m_dur[l] = m_rd[l] ? 1 + lat_of(l) : 1;
        m_t[l] = 0;
        m_act[l] = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int l = 0; l < NL; l++) begin
        logic       e_re, e_a0, e_a1;
        logic [3:0] e_we;
        logic [1:0] e_st;
        e_re = m_act[l] && m_rd[l] && (m_t[l] < m_dur[l]);
        e_we = (m_act[l] && !m_rd[l] && m_t[l] == 0) ? m_we[l] : 4'd0;
        e_a0 = m_act[l] && (m_t[l] == m_dur[l]) && !m_own[l];
        e_a1 = m_act[l] && (m_t[l] == m_dur[l]) && m_own[l];
        if (!m_act[l]) e_st = 2'd0;
        else if (m_t[l] == 0) e_st = 2'd1;
        else if (m_t[l] == m_dur[l]) e_st = 2'd3;
        else e_st = 2'd2;
        chk("bus_re", l, 32'(o_re[l]), 32'(e_re));
        chk("bus_we", l, 32'(o_we[l]), 32'(e_we));
        chk("bus_addr", l, o_addr[l], m_addr[l]);
        chk("bus_wdata", l, o_wdata[l], m_wdata[l]);
        chk("m0_ack", l, 32'(o_ack0[l]), 32'(e_a0));
        chk("m1_ack", l, 32'(o_ack1[l]), 32'(e_a1));
        chk("busy", l, 32'(o_busy[l]), 32'(m_act[l]));
        chk("owner", l, 32'(o_owner[l]), 32'(m_own[l]));
        chk("state", l, 32'(o_state[l]), 32'(e_st));
        if ((e_a0 || e_a1) && m_rd[l]) chk("m_rdata", l, o_rdata[l], m_rdat[l]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_txn(input int l, input int m, input logic [3:0] we,
                         input logic [31:0] ad, input logic [31:0] wd);
    rq[l][m] = 1'b1;
    we_a[l][m] = we;
    ad_a[l][m] = ad;
    wd_a[l][m] = wd;
  endtask

  task automatic new_req(input int l, input int m);
    set_txn(l, m, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0,
            $urandom(), $urandom());
  endtask

  // One cycle: move to the next negedge, then play bus and masters.
  task automatic tick();
    logic ackd;
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      if (mode != 0 && !o_re[l]) resp[l] = $urandom();
      if (o_re[l]) re_run[l]++;
      else re_run[l] = 0;
      bus_rdata[l] = (o_re[l] && re_run[l] == lat_of(l) + 1) ? resp[l] : $urandom();
      for (int m = 0; m < 2; m++) begin
        ackd = (m == 1) ? o_ack1[l] : o_ack0[l];
        if (ackd) begin
          waiting[l][m] = 1'b0;
          if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) new_req(l, m);
          else rq[l][m] = 1'b0;
        end else if (mode == 2) begin
          if (!rq[l][m] && !waiting[l][m]) begin
            if ($urandom_range(0, 3) == 0) new_req(l, m);
          end else if (rq[l][m] && m_act[l] && m_own[l] == 1'(m) &&
                       m_t[l] < m_dur[l] && $urandom_range(0, 15) == 0) begin
            rq[l][m] = 1'b0;        // early withdrawal after grant
            waiting[l][m] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int l = 0; l < NL; l++) begin rq[l][0] = 1'b0; rq[l][1] = 1'b0; end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  int first_k[NL], re_cnt[NL], ack_cnt[NL], bad[NL], we_k[NL];
  int seq[NL][$];
  logic [31:0] ack_data[NL];

  initial begin
    mode = 0;
    chk_en = 1'b0;
    for (int l = 0; l < NL; l++) begin
      for (int m = 0; m < 2; m++) begin
        rq[l][m] = 1'b0; we_a[l][m] = '0; ad_a[l][m] = '0; wd_a[l][m] = '0;
        waiting[l][m] = 1'b0;
      end
      bus_rdata[l] = '0; resp[l] = '0; re_run[l] = 0;
    end
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    for (int l = 0; l < NL; l++) begin
      chk("rst_busy", l, 32'(o_busy[l]), 32'd0);
      chk("rst_owner", l, 32'(o_owner[l]), 32'd0);
      chk("rst_bus_re", l, 32'(o_re[l]), 32'd0);
      chk("rst_bus_addr", l, o_addr[l], 32'd0);
      chk("rst_m_rdata", l, o_rdata[l], 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Single read by master 0 at 0x100.
    for (int l = 0; l < NL; l++) begin
      resp[l] = 32'hDEADBEEF;
      set_txn(l, 0, 4'd0, 32'h100, 32'h0);
      first_k[l] = -1; re_cnt[l] = 0; ack_cnt[l] = 0; bad[l] = 0; ack_data[l] = '0;
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int l = 0; l < NL; l++) begin
        if (o_re[l]) begin
          re_cnt[l]++;
          if (o_addr[l] != 32'h100) bad[l]++;
        end
        if (o_ack0[l]) begin
          ack_cnt[l]++;
          if (first_k[l] < 0) begin first_k[l] = k + 1; ack_data[l] = o_rdata[l]; end
        end
      end
    end
    for (int l = 0; l < NL; l++) begin
      chk("rd_latency", l, 32'(first_k[l]), 32'(3 + lat_of(l)));
      chk("rd_re_cycles", l, 32'(re_cnt[l]), 32'(1 + lat_of(l)));
      chk("rd_data", l, ack_data[l], 32'hDEADBEEF);
      chk("rd_ack_count", l, 32'(ack_cnt[l]), 32'd1);
      chk("rd_addr_stable", l, 32'(bad[l]), 32'd0);
    end

    // Single write by master 1.
    for (int l = 0; l < NL; l++) begin
      set_txn(l, 1, 4'b0011, 32'h204, 32'h1234);
      re_cnt[l] = 0; bad[l] = 0; we_k[l] = -1; first_k[l] = -1;
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int l = 0; l < NL; l++) begin
        if (o_we[l] != 4'd0) begin
          re_cnt[l]++;
          we_k[l] = k + 1;
          if (o_we[l] != 4'b0011 || o_addr[l] != 32'h204 || o_wdata[l] != 32'h1234) bad[l]++;
        end
        if (o_ack1[l] && first_k[l] < 0) first_k[l] = k + 1;
      end
    end
    for (int l = 0; l < NL; l++) begin
      chk("wr_we_cycles", l, 32'(re_cnt[l]), 32'd1);
      chk("wr_fields", l, 32'(bad[l]), 32'd0);
      chk("wr_ack_cycle", l, 32'(first_k[l]), 32'd3);
      chk("wr_ack_after_we", l, 32'(first_k[l] - we_k[l]), 32'd1);
    end

    // Continuous contention from reset.
    do_reset();
    mode = 1;
    for (int l = 0; l < NL; l++) begin
      new_req(l, 0); new_req(l, 1);
      bad[l] = 0; seq[l].delete();
    end
    for (int k = 0; k < 60; k++) begin
      tick();
      for (int l = 0; l < NL; l++) begin
        if (o_ack0[l] && o_ack1[l]) bad[l]++;
        if (o_ack0[l]) seq[l].push_back(0);
        if (o_ack1[l]) seq[l].push_back(1);
      end
    end
    mode = 0;
    for (int l = 0; l < NL; l++) begin
      int alt_bad;
      alt_bad = 0;
      foreach (seq[l][i]) if (seq[l][i] != (i % 2)) alt_bad++;
      chk("cont_both_acks", l, 32'(bad[l]), 32'd0);
      chk("cont_alternation", l, 32'(alt_bad), 32'd0);
      chk("cont_enough_acks", l, 32'(seq[l].size() >= 6), 32'd1);
      rq[l][0] = 1'b0; rq[l][1] = 1'b0;
    end
    repeat (10) tick();

    // Reset during a read, then master 1 alone.
    for (int l = 0; l < NL; l++) set_txn(l, 0, 4'd0, 32'h280, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    for (int l = 0; l < NL; l++) begin
      rq[l][0] = 1'b0;
      set_txn(l, 1, 4'd0, 32'h300, 32'h0);
      ack_cnt[l] = 0; first_k[l] = -1;
    end
    tick();
    for (int l = 0; l < NL; l++) begin
      chk("abort_bus_re", l, 32'(o_re[l]), 32'd0);
      chk("abort_busy", l, 32'(o_busy[l]), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      for (int l = 0; l < NL; l++) begin
        if (o_ack0[l]) ack_cnt[l]++;
        if (k == 1) chk("post_rst_owner", l, 32'(o_owner[l]), 32'd1);
        if (o_ack1[l] && first_k[l] < 0) first_k[l] = k;
      end
    end
    for (int l = 0; l < NL; l++) begin
      chk("abort_no_m0_ack", l, 32'(ack_cnt[l]), 32'd0);
      chk("post_rst_m1_served", l, 32'(first_k[l] > 0), 32'd1);
    end

    // Master 0 withdraws its read after grant.
    for (int l = 0; l < NL; l++) begin
      set_txn(l, 0, 4'd0, 32'h400, 32'h0);
      ack_cnt[l] = 0;
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) for (int l = 0; l < NL; l++) rq[l][0] = 1'b0;
      for (int l = 0; l < NL; l++) if (o_ack0[l]) ack_cnt[l]++;
    end
    for (int l = 0; l < NL; l++) begin
      chk("drop_ack_once", l, 32'(ack_cnt[l]), 32'd1);
      chk("drop_idle", l, 32'(o_busy[l]), 32'd0);
    end

    // Random traffic against the model.
    for (int l = 0; l < NL; l++) begin waiting[l][0] = 1'b0; waiting[l][1] = 1'b0; end
    mode = 2;
    repeat (2000) tick();
    mode = 0;
    for (int l = 0; l < NL; l++) begin rq[l][0] = 1'b0; rq[l][1] = 1'b0; end
    repeat (12) tick();
    for (int l = 0; l < NL; l++) chk("final_idle", l, 32'(o_busy[l]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
